uart_rx_frame: RTL and testbench
================================

UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 SHALL have parameter DELAY_FRAMES, default 2812, clock cycles per bit (27 MHz / 9600 baud).
REQ-002 SHALL have parameter HALF_DELAY_WAIT, default DELAY_FRAMES/2 (1406), start-bit midpoint offset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two; used only with UART_RX_FIFO_EN.
REQ-004 SHALL use one clock and asynchronous active-low reset; ports clk and rst.
REQ-005 clk  input  1  system clock, 27 MHz.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 uart_rx  input  1  serial line, idle high, 8N1, LSB first.
REQ-008 rd_en  input  1  consumer pops head byte.
REQ-009 data_out  output  8  head received byte.
REQ-010 data_valid  output  1  data_out holds an unread byte.
REQ-011 frame_err  output  1  one-cycle pulse, stop bit sampled 0.
REQ-012 overrun  output  1  one-cycle pulse, byte dropped because storage full.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL pass uart_rx through a two-flop synchronizer, reset value 1; all decoding uses the synchronized value.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE -> START on synchronized 1->0 transition; bit counter cleared.
REQ-017 START: after HALF_DELAY_WAIT cycles, sample; 0 -> DATA with counter cleared; 1 -> IDLE (glitch), no output.
REQ-018 DATA: sample every DELAY_FRAMES cycles; shift 8 bits LSB first; 3-bit index; after bit 7 -> STOP.
REQ-019 STOP: sample after DELAY_FRAMES; 1 -> push byte, IDLE; 0 -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE when synchronized line is 1; no new start detection before then.
REQ-021 Byte SHALL be visible on data_out with data_valid high on the cycle after the stop-bit sample.
REQ-022 rd_en while data_valid=0 SHALL be ignored; rd_en with data_valid=1 removes head, next byte appears on the following cycle.
REQ-023 Push when full without simultaneous pop SHALL drop the new byte and pulse overrun; stored bytes unchanged.
REQ-024 Simultaneous push and pop SHALL both succeed in every occupancy, including full.
REQ-025 Bit-period counter SHALL be 12 bits wide, wraps only via explicit clear; no free-running wrap.

Reset
REQ-026 Assertion of rst SHALL asynchronously force: state IDLE, counters 0, storage empty, data_out 8'h00, data_valid 0, frame_err 0, overrun 0, busy 0, synchronizer flops 1.
REQ-027 Reset mid-frame SHALL abandon the partial byte; after release the next falling edge starts a fresh frame.

Configuration
REQ-028 Macro UART_RX_FIFO_EN defined: storage is a FIFO of FIFO_DEPTH entries, show-ahead head on data_out.
REQ-029 Macro undefined: storage is a single holding register; data_valid set on push, cleared by rd_en; push while valid and no rd_en -> overrun, register retained.

Structure
REQ-030 Package uart_pkg SHALL hold DELAY_FRAMES, HALF_DELAY_WAIT and the rx state enum typedef, shared with the transmit path.
REQ-031 Storage SHALL be sub-module uart_rx_fifo (ports clk, rst, push, din, pop, dout, valid, full) instantiated only under UART_RX_FIFO_EN.

Verification
REQ-032 Send 0x41 ('A') at 2812 cycles/bit -> data_valid=1, data_out=8'h41 one cycle after stop sample; rd_en -> data_valid=0.
REQ-033 Drive uart_rx low 500 cycles then high -> no data_valid, no frame_err, busy returns 0.
REQ-034 Send 0x32 with stop bit 0, line held low 3000 cycles -> single frame_err pulse, no data, no restart until line high.
REQ-035 With FIFO_EN, send 0x31..0x35 without reads -> 0x31..0x34 read back in order, overrun pulse at fifth stop sample.
REQ-036 Assert rst at DATA bit 3 of 0x55, release, send 0x44 -> only 0x44 received.
REQ-037 Back-to-back "2","5" (no idle gap) with rd_en held high -> both bytes delivered in order, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing for 27 MHz / 9600 baud and the
// receive state encoding, used by both the receive and transmit paths.
package uart_pkg;

  localparam int DELAY_FRAMES    = 2812;
  localparam int HALF_DELAY_WAIT = DELAY_FRAMES / 2;
  localparam int CNT_W           = 12;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Received-byte consumer interface: the receiver (master) presents bytes and
// status pulses, the consumer (slave) pops with rd_en.
interface uart_rx_frame_if;

  logic       rd_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rd_en,
    output data_out, data_valid, frame_err, overrun, busy
  );

  modport slave (
    output rd_en,
    input  data_out, data_valid, frame_err, overrun, busy
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO for the UART receiver; a push while full succeeds only
// when a pop happens on the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // When full with a pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with single-register byte storage, or a FIFO of
// FIFO_DEPTH entries when UART_RX_FIFO_EN is defined.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES    = uart_pkg::DELAY_FRAMES,
  parameter int HALF_DELAY_WAIT = DELAY_FRAMES / 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rx,
  uart_rx_frame_if.master rx_if
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DELAY_WAIT - 1);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic             rx_sync_p0, rx_sync_p1, rx_prev_p2;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q;
  logic             shift_en, push, frame_err_d, overrun_d;
  logic             frame_err_q, overrun_q;

  // Stage p0/p1: metastability synchronizer; p2: previous value for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev_p2 <= rx_sync_p1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {rx_sync_p1, shift_q[7:1]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_en    = 1'b0;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (rx_prev_p2 && !rx_sync_p1) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_p1 ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_en  = 1'b1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_sync_p1) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_sync_p1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  logic fifo_full;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift_q),
    .pop   (rx_if.rd_en),
    .dout  (rx_if.data_out),
    .valid (rx_if.data_valid),
    .full  (fifo_full)
  );

  assign overrun_d = push & fifo_full & ~(rx_if.rd_en & rx_if.data_valid);
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  // A push while the register is being read replaces the byte in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
    end else if (push && (!hold_vld_q || rx_if.rd_en)) begin
      hold_q     <= shift_q;
      hold_vld_q <= 1'b1;
    end else if (rx_if.rd_en) begin
      hold_vld_q <= 1'b0;
    end
  end

  assign rx_if.data_out   = hold_q;
  assign rx_if.data_valid = hold_vld_q;
  assign overrun_d        = push & hold_vld_q & ~rx_if.rd_en;
`endif

  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed/random bench for uart_rx_frame at a shortened bit period; a byte
// scoreboard tracks which bytes must reach the consumer.
module tb_uart_rx_frame;

  localparam int DF = 16;
  localparam int HW = 8;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;

  uart_rx_frame_if ifc ();

  uart_rx_frame #(
    .DELAY_FRAMES    (DF),
    .HALF_DELAY_WAIT (HW),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .rx_if   (ifc)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int fe_cnt      = 0;
  int ov_cnt      = 0;
  logic [7:0] popped   [$];
  logic [7:0] expected [$];

  // Observe the consumer side away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (ifc.data_valid && ifc.rd_en) popped.push_back(ifc.data_out);
      if (ifc.frame_err) fe_cnt++;
      if (ifc.overrun)   ov_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(DF);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(DF);
    end
    uart_rx = stop_bit;
    tick(DF);
  endtask

  task automatic read_one();
    ifc.rd_en = 1'b1;
    tick(1);
    ifc.rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] b, a;
    int fe0, ov0;

    rst       = 1'b0;
    uart_rx   = 1'b1;
    ifc.rd_en = 1'b0;
    tick(3);
    check("reset_data_valid", 32'(ifc.data_valid), 32'd0);
    check("reset_data_out",   32'(ifc.data_out),   32'h00);
    check("reset_frame_err",  32'(ifc.frame_err),  32'd0);
    check("reset_overrun",    32'(ifc.overrun),    32'd0);
    check("reset_busy",       32'(ifc.busy),       32'd0);
    rst = 1'b1;
    tick(2);

    read_one();
    check("empty_read_ignored", 32'(ifc.data_valid), 32'd0);

    send_frame(8'h41, 1'b1);
    expected.push_back(8'h41);
    check("A_valid", 32'(ifc.data_valid), 32'd1);
    check("A_data",  32'(ifc.data_out),   32'h41);
    check("A_idle",  32'(ifc.busy),       32'd0);
    read_one();
    check("A_cleared", 32'(ifc.data_valid), 32'd0);

    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      expected.push_back(b);
      check("rand_valid", 32'(ifc.data_valid), 32'd1);
      check("rand_data",  32'(ifc.data_out),   32'(b));
      read_one();
      check("rand_cleared", 32'(ifc.data_valid), 32'd0);
    end

    // Short low pulse: rejected at the start-bit midpoint.
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    tick(5);
    uart_rx = 1'b1;
    tick(3 * DF);
    check("glitch_no_data", 32'(ifc.data_valid), 32'd0);
    check("glitch_no_ferr", 32'(fe_cnt - fe0),   32'd0);
    check("glitch_idle",    32'(ifc.busy),       32'd0);

    // Bad stop bit with the line held low afterwards.
    send_frame(8'h32, 1'b0);
    tick(2 * DF);
    check("ferr_single_pulse", 32'(fe_cnt - fe0),   32'd1);
    check("ferr_no_data",      32'(ifc.data_valid), 32'd0);
    check("ferr_wait_high",    32'(ifc.busy),       32'd1);
    uart_rx = 1'b1;
    tick(4);
    check("ferr_released",   32'(ifc.busy),     32'd0);
    check("ferr_no_restart", 32'(fe_cnt - fe0), 32'd1);

    ov0 = ov_cnt;
`ifdef UART_RX_FIFO_EN
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h31 + 8'(k), 1'b1);
      if (k < 4) expected.push_back(8'h31 + 8'(k));
      if (k == 3) check("fifo_no_overrun_yet", 32'(ov_cnt - ov0), 32'd0);
    end
    check("fifo_overrun", 32'(ov_cnt - ov0),  32'd1);
    check("fifo_head",    32'(ifc.data_out),  32'h31);
    for (int k = 0; k < 4; k++) read_one();
    check("fifo_drained", 32'(ifc.data_valid), 32'd0);
`else
    a = 8'($urandom);
    b = ~a;
    send_frame(a, 1'b1);
    send_frame(b, 1'b1);
    expected.push_back(a);
    check("hold_overrun",  32'(ov_cnt - ov0),  32'd1);
    check("hold_retained", 32'(ifc.data_out),  32'(a));
    read_one();
    check("hold_drained", 32'(ifc.data_valid), 32'd0);
`endif

    // Reset in the middle of data bit 3 of 0x55.
    b = 8'h55;
    uart_rx = 1'b0;
    tick(DF);
    for (int i = 0; i < 3; i++) begin
      uart_rx = b[i];
      tick(DF);
    end
    uart_rx = b[3];
    tick(DF / 2);
    rst = 1'b0;
    #1;
    check("midreset_idle",  32'(ifc.busy),       32'd0);
    check("midreset_empty", 32'(ifc.data_valid), 32'd0);
    tick(2);
    uart_rx = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(DF);
    send_frame(8'h44, 1'b1);
    expected.push_back(8'h44);
    check("postreset_valid", 32'(ifc.data_valid), 32'd1);
    check("postreset_data",  32'(ifc.data_out),   32'h44);
    read_one();

    // Back-to-back frames with the consumer always reading.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    ifc.rd_en = 1'b1;
    send_frame(8'h32, 1'b1);
    send_frame(8'h35, 1'b1);
    tick(2);
    ifc.rd_en = 1'b0;
    expected.push_back(8'h32);
    expected.push_back(8'h35);
    check("b2b_no_ferr",    32'(fe_cnt - fe0),   32'd0);
    check("b2b_no_overrun", 32'(ov_cnt - ov0),   32'd0);
    check("b2b_empty",      32'(ifc.data_valid), 32'd0);

    check("stream_length", 32'(popped.size()), 32'(expected.size()));
    for (int i = 0; i < expected.size(); i++) begin
      if (i < popped.size()) check($sformatf("stream_byte_%0d", i), 32'(popped[i]), 32'(expected[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
